// File: rtl/mole_pkg.sv
// mole_pkg: shared types and constants for the whack-a-mole control stage.
//   - mole_state_e : control FSM states (idle, mole shown, waiting for tick, game over)
//   - LfsrWidth / LfsrTaps : 16-bit Galois LFSR, taps 16,14,13,11
//   - pos_width()  : bits needed to index N_HOLES holes
package mole_pkg;

  localparam int unsigned LfsrWidth = 16;
  // Right-shifting Galois form: taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [LfsrWidth-1:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StWait,
    StOver
  } mole_state_e;

  function automatic int unsigned pos_width(input int unsigned n_holes);
    return (n_holes > 1) ? $clog2(n_holes) : 1;
  endfunction

endpackage

// File: rtl/mole_if.sv
// mole_if: game-side signal bundle between the board and mole_ctrl.
//   master : drives move_clk, start, btn; observes the game outputs
//   slave  : mole_ctrl side
//   move_clk  divided square wave from the move-rate divider
//   start     start/restart request (level)
//   btn       debounced buttons, active high
//   mole      one-hot lit hole, zero when dark
//   score     saturating hit count
//   misses    miss count
//   hit       one-cycle pulse per hit
//   game_over high while the game is over
interface mole_if #(
  parameter int unsigned N_HOLES = 4,
  parameter int unsigned SCORE_W = 8
);
  logic               move_clk;
  logic               start;
  logic [N_HOLES-1:0] btn;
  logic [N_HOLES-1:0] mole;
  logic [SCORE_W-1:0] score;
  logic [2:0]         misses;
  logic               hit;
  logic               game_over;

  modport master (
    output move_clk, start, btn,
    input  mole, score, misses, hit, game_over
  );

  modport slave (
    input  move_clk, start, btn,
    output mole, score, misses, hit, game_over
  );
endinterface

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Galois LFSR, steps every clk cycle.
//   clk   system clock
//   rst   synchronous active-high reset, loads SEED (must be nonzero)
//   state current LFSR contents
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [LfsrWidth-1:0] state
);

  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LfsrTaps;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/mole_ctrl.sv
// mole_ctrl: whack-a-mole game control. Turns rising edges of the slow move clock into move
// ticks, places the mole from an LFSR, scores presses on the lit hole and ends the game after
// MAX_MISS missed ticks. All outputs are registered (one cycle after the deciding input).
//   clk  system clock        rst  synchronous active-high reset
//   bus  mole_if.slave: move_clk, start, btn in; mole, score, misses, hit, game_over out
// Optional build macro MOLE_NO_REPEAT_EN: a reposition that would land on the current hole
// moves one hole further instead, so the mole never shows twice in a row in the same hole.
module mole_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned          N_HOLES   = 4,
  parameter int unsigned          SCORE_W   = 8,
  parameter int unsigned          MAX_MISS  = 3,
  parameter logic [LfsrWidth-1:0] LFSR_SEED = 16'hACE1
) (
  input logic   clk,
  input logic   rst,
  mole_if.slave bus
);

  localparam int unsigned        PosW      = pos_width(N_HOLES);
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  localparam logic [2:0]         MissLimit = 3'(MAX_MISS);
  localparam logic [N_HOLES-1:0] OneHot0   = N_HOLES'(1);

  logic [LfsrWidth-1:0] lfsr;
  logic                 move_clk_q, tick;
  logic [N_HOLES-1:0]   btn_q, press;
  mole_state_e          state_q, state_d;
  logic [PosW-1:0]      pos_q, pos_d, cand, repos;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           misses_q, misses_d;
  logic                 hit_q, hit_d;
  logic [N_HOLES-1:0]   mole_q, mole_d;
  logic                 game_over_q;
  logic                 unused_lfsr;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign cand        = lfsr[PosW-1:0];
  assign unused_lfsr = ^lfsr[LfsrWidth-1:PosW];

  assign tick  = bus.move_clk & ~move_clk_q;
  assign press = bus.btn & ~btn_q;

`ifdef MOLE_NO_REPEAT_EN
  // N_HOLES is a power of two, so the wrap of pos_q + 1 is the modulo.
  assign repos = (cand == pos_q) ? pos_q + PosW'(1) : cand;
`else
  assign repos = cand;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          score_d  = '0;
          misses_d = '0;
          pos_d    = repos;
          state_d  = StShow;
        end
      end
      StShow: begin
        if (press[pos_q]) begin
          // A hit landing on a tick takes priority: no miss, mole moves straight on.
          hit_d   = 1'b1;
          pos_d   = repos;
          state_d = tick ? StShow : StWait;
          if (score_q != ScoreMax) score_d = score_q + SCORE_W'(1);
        end else if (tick) begin
          misses_d = misses_q + 3'd1;
          if (misses_d == MissLimit) state_d = StOver;
          else                       pos_d   = repos;
        end
      end
      StWait: begin
        if (tick) state_d = StShow;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output image is computed from the next state so mole/game_over are registered.
  always_comb begin
    mole_d = '0;
    if (state_d == StShow) mole_d = OneHot0 << pos_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      move_clk_q  <= 1'b0;
      btn_q       <= '0;
      state_q     <= StIdle;
      pos_q       <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      hit_q       <= 1'b0;
      mole_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      move_clk_q  <= bus.move_clk;
      btn_q       <= bus.btn;
      state_q     <= state_d;
      pos_q       <= pos_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_q       <= hit_d;
      mole_q      <= mole_d;
      game_over_q <= (state_d == StOver);
    end
  end

  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.hit       = hit_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_mole_ctrl.sv
// tb_mole_ctrl: directed self-checking bench for mole_ctrl (N_HOLES=4, SCORE_W=8, MAX_MISS=3).
// Inputs change and outputs are sampled on the falling clock edge. A reference LFSR tracks the
// expected mole position; define MOLE_NO_REPEAT_EN to match a no-repeat build.
module tb_mole_ctrl;

  localparam logic [15:0] Seed = 16'hACE1;
`ifdef MOLE_NO_REPEAT_EN
  localparam bit NoRepeat = 1'b1;
`else
  localparam bit NoRepeat = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] m_lfsr;
  logic [1:0]  exp_pos;
  int          n_tests;
  int          n_fail;

  mole_if #(.N_HOLES(4), .SCORE_W(8)) bus ();

  mole_ctrl #(
    .N_HOLES   (4),
    .SCORE_W   (8),
    .MAX_MISS  (3),
    .LFSR_SEED (Seed)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: Galois, taps 16,14,13,11, one step per clock.
  always @(posedge clk) begin
    if (rst) m_lfsr <= Seed;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [1:0] exp_next(input logic [15:0] l, input logic [1:0] prev);
    logic [1:0] c;
    c = l[1:0];
    if (NoRepeat && c == prev) c = prev + 2'd1;
    return c;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.btn = '0; bus.move_clk = 1'b0;
    step(); step();
    rst = 1'b0;
    exp_pos = 2'd0;
  endtask

  task automatic do_start();
    exp_pos = exp_next(m_lfsr, exp_pos);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // One move tick; caller leaves at least one cycle before the next tick.
  task automatic tick_cycle();
    bus.move_clk = 1'b1;
    step();
    bus.move_clk = 1'b0;
  endtask

  // Press and release the lit hole; leaves the game in WAIT.
  task automatic press_lit();
    logic [1:0] np;
    np = exp_next(m_lfsr, exp_pos);
    bus.btn = oh(exp_pos);
    step();
    bus.btn = '0;
    exp_pos = np;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.btn = '0; bus.move_clk = 1'b0;
    step(); step(); step();
    n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL rst_held_mole got=%b exp=0000", bus.mole); end
    rst = 1'b0; exp_pos = 2'd0;
    step();
    n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL rst_mole got=%b exp=0000", bus.mole); end
    n_tests++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL rst_score got=%0d exp=0", bus.score); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL rst_misses got=%0d exp=0", bus.misses); end
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit got=%b exp=0", bus.hit); end
    n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL rst_over got=%b exp=0", bus.game_over); end
    // Tick and buttons in IDLE do nothing.
    bus.move_clk = 1'b1; bus.btn = 4'hF;
    step();
    bus.move_clk = 1'b0; bus.btn = '0;
    step();
    n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL idle_mole got=%b exp=0000", bus.mole); end
    n_tests++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL idle_score got=%0d exp=0", bus.score); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL idle_misses got=%0d exp=0", bus.misses); end
  endtask

  task automatic test_hits();
    int hits;
    hits = 0;
    do_reset();
    do_start();
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL start_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
    n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL start_over got=%b exp=0", bus.game_over); end
    for (int i = 0; i < 5; i++) begin
      press_lit();
      if (bus.hit === 1'b1) hits++;
      n_tests++; if (bus.score !== 8'(i + 1)) begin n_fail++; $display("FAIL hit_score got=%0d exp=%0d", bus.score, i + 1); end
      n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL wait_dark got=%b exp=0000", bus.mole); end
      step();
      if (bus.hit === 1'b1) hits++;
      tick_cycle();
      if (bus.hit === 1'b1) hits++;
      n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL wait_show got=%b exp=%b", bus.mole, oh(exp_pos)); end
      step();
    end
    n_tests++; if (hits != 5) begin n_fail++; $display("FAIL hit_pulses got=%0d exp=5", hits); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL hit_misses got=%0d exp=0", bus.misses); end
  endtask

  task automatic test_misses();
    logic [1:0] np;
    do_reset();
    do_start();
    press_lit(); step(); tick_cycle(); step();
    for (int k = 1; k <= 3; k++) begin
      np = exp_next(m_lfsr, exp_pos);
      tick_cycle();
      n_tests++; if (bus.misses !== 3'(k)) begin n_fail++; $display("FAIL miss_count got=%0d exp=%0d", bus.misses, k); end
      if (k < 3) begin
        exp_pos = np;
        n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL miss_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
        n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL miss_over got=%b exp=0", bus.game_over); end
      end else begin
        n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL over_mole got=%b exp=0000", bus.mole); end
        n_tests++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag got=%b exp=1", bus.game_over); end
      end
      step();
    end
    n_tests++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL over_score_hold got=%0d exp=1", bus.score); end
    do_start();
    n_tests++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL restart_score got=%0d exp=0", bus.score); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL restart_misses got=%0d exp=0", bus.misses); end
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL restart_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
    n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL restart_over got=%b exp=0", bus.game_over); end
  endtask

  task automatic test_hit_on_tick();
    logic [1:0] np;
    do_reset();
    do_start();
    np = exp_next(m_lfsr, exp_pos);
    tick_cycle();
    exp_pos = np;
    step();
    np = exp_next(m_lfsr, exp_pos);
    bus.btn = oh(exp_pos); bus.move_clk = 1'b1;
    step();
    bus.btn = '0; bus.move_clk = 1'b0;
    exp_pos = np;
    n_tests++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL tickhit_hit got=%b exp=1", bus.hit); end
    n_tests++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL tickhit_score got=%0d exp=1", bus.score); end
    n_tests++; if (bus.misses !== 3'd1) begin n_fail++; $display("FAIL tickhit_misses got=%0d exp=1", bus.misses); end
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL tickhit_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
    step();
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL tickhit_nowait got=%b exp=%b", bus.mole, oh(exp_pos)); end
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL tickhit_pulse got=%b exp=0", bus.hit); end
  endtask

  task automatic test_hold_and_other();
    logic [1:0] np;
    logic [1:0] other;
    int         hits;
    hits = 0;
    do_reset();
    do_start();
    np = exp_next(m_lfsr, exp_pos);
    bus.btn = oh(exp_pos);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.hit === 1'b1) hits++;
    end
    bus.btn = '0;
    exp_pos = np;
    n_tests++; if (hits != 1) begin n_fail++; $display("FAIL hold_hits got=%0d exp=1", hits); end
    n_tests++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL hold_score got=%0d exp=1", bus.score); end
    step();
    tick_cycle();
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL hold_show got=%b exp=%b", bus.mole, oh(exp_pos)); end
    step();
    other = exp_pos + 2'd1;
    bus.btn = oh(other);
    step();
    bus.btn = '0;
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL other_hit got=%b exp=0", bus.hit); end
    n_tests++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL other_score got=%0d exp=1", bus.score); end
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL other_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL other_misses got=%0d exp=0", bus.misses); end
  endtask

  // 256 hits: saturation at 255 plus 256 repositions checked against the reference.
  task automatic test_saturate();
    logic [1:0] prev;
    do_reset();
    do_start();
    for (int i = 0; i < 256; i++) begin
      prev = exp_pos;
      press_lit();
      n_tests++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL sat_hit i=%0d got=%b exp=1", i, bus.hit); end
      if (i == 254) begin
        n_tests++; if (bus.score !== 8'd255) begin n_fail++; $display("FAIL sat_reach got=%0d exp=255", bus.score); end
      end
      step();
      tick_cycle();
      n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL repos_mole i=%0d got=%b exp=%b", i, bus.mole, oh(exp_pos)); end
`ifdef MOLE_NO_REPEAT_EN
      n_tests++; if (bus.mole === oh(prev)) begin n_fail++; $display("FAIL norepeat i=%0d got=%b exp!=%b", i, bus.mole, oh(prev)); end
`endif
      step();
    end
    n_tests++; if (bus.score !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", bus.score); end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    do_start();
    press_lit(); step(); tick_cycle(); step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_tests++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL show_start_score got=%0d exp=1", bus.score); end
    n_tests++; if (bus.mole !== oh(exp_pos)) begin n_fail++; $display("FAIL show_start_mole got=%b exp=%b", bus.mole, oh(exp_pos)); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pos = 2'd0;
    n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL midrst_mole got=%b exp=0000", bus.mole); end
    n_tests++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL midrst_score got=%0d exp=0", bus.score); end
    n_tests++; if (bus.misses !== 3'd0) begin n_fail++; $display("FAIL midrst_misses got=%0d exp=0", bus.misses); end
    n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL midrst_over got=%b exp=0", bus.game_over); end
    step();
    tick_cycle();
    n_tests++; if (bus.mole !== 4'd0) begin n_fail++; $display("FAIL midrst_idle got=%b exp=0000", bus.mole); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; bus.start = 1'b0; bus.btn = '0; bus.move_clk = 1'b0;
    exp_pos = 2'd0;
    test_reset();
    test_hits();
    test_misses();
    test_hit_on_tick();
    test_hold_and_other();
    test_saturate();
    test_reset_mid_show();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
